uart_rx_fifo: RTL

Parametrised UART receiver with a built-in receive FIFO and error reporting. It is the successor to the fixed 8N1 receiver that SYSTEM currently uses on `rxd`, and adds configurable data width, parity, stop bits, runtime baud divisor, buffering and sticky error flags. It sits between the `rxd` pad and the CPU peripheral bus. The CPU drains bytes with a read strobe.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 63 ++++++
 rtl/uart_rx_fifo.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path (and the future transmitter):
// parity mode encodings, the receiver FSM state type and the smallest baud
// divisor the bit timing can tolerate.
// ---------------------------------------------------------------------------
package uart_pkg;

  // Parity mode encodings for the PARITY parameter
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Below this the half-bit start delay gets too short to land mid-bit
  localparam int MIN_DIVISOR = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO, shared by the UART receiver and
// transmitter.
//
// Ports:
//   clk, reset  - clock and synchronous active-high reset (empties the FIFO)
//   push, din   - write request and data; accepted when not full, or when
//                 full but a pop happens in the same cycle
//   pop         - read request; ignored when empty
//   dout        - head entry, forced to 0 while empty
//   full, empty - occupancy status
//   count       - number of stored entries
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra bit so full and empty are distinguishable
  assign count   = wptr - rptr;
  assign empty   = (wptr == rptr);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees the head slot this cycle, so a full FIFO can still accept
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rptr[AW-1:0]];

  // Pointer registers; reset discards all contents
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  // Storage array; no reset needed since empty masks stale contents
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Parametrised UART receiver with a receive FIFO and sticky error flags.
//
// Ports:
//   clk, reset  - system clock, synchronous active-high reset
//   rxd         - asynchronous serial input, idles high
//   divisor     - clocks per bit, latched at each start-bit detection
//   rd          - pop strobe for the FIFO head
//   dout, dv    - FIFO head (first-word-fall-through) and not-empty
//   count       - FIFO occupancy
//   parity_err  - sticky parity mismatch on a stored byte
//   frame_err   - sticky, some stop bit sampled low (byte discarded)
//   overrun     - sticky, a good byte was dropped on a full FIFO
//   clr_err     - clears the sticky flags (a same-cycle set wins)
// ---------------------------------------------------------------------------
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int DIV_W     = 16,
  parameter int DEPTH     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rxd,
  input  logic [DIV_W-1:0]       divisor,
  input  logic                   rd,
  output logic [DATA_BITS-1:0]   dout,
  output logic                   dv,
  output logic [$clog2(DEPTH):0] count,
  output logic                   parity_err,
  output logic                   frame_err,
  output logic                   overrun,
  input  logic                   clr_err
);

  logic                 sync1;
  logic                 rxs;
  logic                 rxs_d;
  logic                 fall;
  rx_state_e            state;
  rx_state_e            next_state;
  logic [DIV_W-1:0]     cnt;
  logic [DIV_W-1:0]     div_q;
  logic                 tick;
  logic [DATA_BITS-1:0] shreg;
  logic [3:0]           bit_idx;
  logic [1:0]           stop_idx;
  logic                 last_data;
  logic                 last_stop;
  logic                 par_pend;
  logic                 stop_bad;
  logic                 start_det;
  logic                 frame_done;
  logic                 frame_ok;
  logic                 frame_bad;
  logic                 push;
  logic                 par_set;
  logic                 ovr_set;
  logic                 fifo_full;
  logic                 fifo_empty;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection;
  // all reset high so a reset never looks like a start edge
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      sync1 <= rxd;
      rxs   <= sync1;
      rxs_d <= rxs;
    end
  end

  assign fall      = rxs_d && !rxs;
  // Counter expiry marks a sample point
  assign tick      = (cnt == DIV_W'(1));
  assign last_data = (bit_idx == 4'(DATA_BITS - 1));
  assign last_stop = (stop_idx == 2'(STOP_BITS - 1));

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // FSM next-state logic; STOP leaves on its final sample (mid bit) so a
  // back-to-back start edge is still caught in IDLE
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (fall) next_state = S_START;
      S_START:  if (tick) next_state = rxs ? S_IDLE : S_DATA;
      S_DATA:   if (tick && last_data)
                  next_state = (PARITY == PAR_NONE) ? S_STOP : S_PARITY;
      S_PARITY: if (tick) next_state = S_STOP;
      S_STOP:   if (tick && last_stop) next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // FSM outputs: start detection, end-of-frame outcome and FIFO/flag strobes
  always_comb begin
    start_det  = 1'b0;
    frame_done = 1'b0;
    case (state)
      S_IDLE:  start_det  = fall;
      S_STOP:  frame_done = tick && last_stop;
      default: ;
    endcase
    frame_ok  = frame_done && !stop_bad && rxs;
    frame_bad = frame_done && (stop_bad || !rxs);
    push      = frame_ok && (!fifo_full || rd);
    ovr_set   = frame_ok && fifo_full && !rd;
    par_set   = push && par_pend;
  end

  // Bit timing and frame datapath: counter, shift register, parity and stop
  // checks. The first expiry lands mid start bit, later ones one bit apart.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      div_q    <= '0;
      shreg    <= '0;
      bit_idx  <= '0;
      stop_idx <= '0;
      par_pend <= 1'b0;
      stop_bad <= 1'b0;
    end else if (start_det) begin
      cnt      <= divisor >> 1;
      div_q    <= divisor;
      bit_idx  <= '0;
      stop_idx <= '0;
      par_pend <= 1'b0;
      stop_bad <= 1'b0;
    end else if (state != S_IDLE) begin
      cnt <= tick ? div_q : cnt - DIV_W'(1);
      if (tick) begin
        case (state)
          S_DATA: begin
            shreg   <= {rxs, shreg[DATA_BITS-1:1]};
            bit_idx <= bit_idx + 4'd1;
          end
          S_PARITY: par_pend <= (((^shreg) ^ rxs) != (PARITY == PAR_ODD));
          S_STOP: begin
            stop_idx <= stop_idx + 2'd1;
            if (!rxs) stop_bad <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Sticky error flags; a set in the same cycle as clr_err keeps the flag high
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      parity_err <= par_set   || (parity_err && !clr_err);
      frame_err  <= frame_bad || (frame_err  && !clr_err);
      overrun    <= ovr_set   || (overrun    && !clr_err);
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (rd),
    .din   (shreg),
    .dout  (dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  assign dv = !fifo_empty;

endmodule
